rp_adder_share_ctrl: RTL and testbench
======================================

// Module: rp_adder_share_ctrl
// PURPOSE
//   Shares one rp_adder_32bit ripple-carry adder among NREQ requesters using round-robin arbitration.
//   Each accepted request's operands are registered into the adder. The block then waits
//   SETTLE_CYCLES clocks, which covers the ripple-carry multicycle path. It captures sum/cout and
//   returns them with a valid/ready response tagged by requester id.
//   It sits between client engines and the shared adder datapath.
// PARAMETERS
//   NREQ           4   number of requesters; must be >= 2
//   SETTLE_CYCLES  2   clocks from operand register to result capture; must be >= 1
//   ID_W           $clog2(NREQ)   localparam; width of the requester id
// PORTS
//   clk        in   1         single clock; all state is on the rising edge
//   rst_n      in   1         asynchronous active-low reset
//   req_valid  in   NREQ      per-requester request valid
//   req_ready  out  NREQ      one-hot acceptance; at most one bit high per cycle
//   req_a      in   NREQ*32   operand A; slice i = [32*i+31:32*i]
//   req_b      in   NREQ*32   operand B, same packing as req_a
//   req_cin    in   NREQ      carry-in per requester
//   rsp_valid  out  1         result available
//   rsp_ready  in   1         consumer accepts result
//   rsp_id     out  ID_W      index of the requester that owns the result
//   rsp_sum    out  32        (a+b+cin) mod 2^32
//   rsp_cout   out  1         bit 32 of a+b+cin
//   busy       out  1         high in any state other than IDLE
//   ops_done   out  32        count of completed response handshakes; wraps at 2^32
// BEHAVIOUR
//   Reset (asynchronous, rst_n=0):
//     - state=IDLE; req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, ops_done=0.
//     - Operand registers=0; last_grant=NREQ-1, so requester 0 has first priority.
//   FSM states: IDLE -> SETTLE -> RESP -> IDLE.
//   IDLE:
//     - If any req_valid is high, grant the first valid requester from index last_grant+1 upward, wrapping mod NREQ.
//     - req_ready[g] is high combinationally in that same cycle.
//     - At the clock edge: register a/b/cin of g into the adder inputs, set last_grant=g, load cnt=SETTLE_CYCLES-1, go to SETTLE.
//   SETTLE:
//     - If cnt!=0, decrement cnt. If cnt==0, capture adder sum/cout into the rsp regs and go to RESP.
//   RESP:
//     - rsp_valid=1. rsp_id/sum/cout stay stable until rsp_valid && rsp_ready.
//     - On that handshake: ops_done+=1 and go to IDLE.
//   req_ready is 0 in every state except IDLE, so there is never more than one operation in flight.
//   Latency:
//     - Request accepted in cycle T -> rsp_valid first high in cycle T+SETTLE_CYCLES+1.
//     - Minimum issue interval is SETTLE_CYCLES+2 cycles.
//   Adder inputs change only on the IDLE->SETTLE edge; they are held through SETTLE and RESP.
//     This makes the multicycle constraint of SETTLE_CYCLES safe.
//   Requesters hold req_valid and data stable until req_ready. A deasserted req_valid simply leaves
//     that requester out of arbitration; no state is kept for it.
//   Arithmetic: 32-bit modulo sum. Carry out goes only to rsp_cout, never saturates.
//   Round-robin is work-conserving: with a single active requester it is granted on every issue slot.
//   Simultaneous events:
//     - rsp handshake and a new req_valid in the same cycle: the new grant happens in the following IDLE cycle.
//   Reset mid-operation: the in-flight op is discarded and no response is produced.
//     Everything returns to reset values, including last_grant.
// STRUCTURE
//   - Shared package rp_adder_pkg holds ADD_W=32 and the FSM state enum
//     {ST_IDLE, ST_SETTLE, ST_RESP} (2-bit encoding).
//   - Sub-module rr_arbiter (NREQ): inputs req and last_grant; outputs a one-hot grant and its encoded index. Purely combinational.
//   - rp_adder_32bit is instantiated internally, driven from the operand registers.
//   - Controller FSM, counter and response registers are in this module.
// TESTING
//   1. Req0 sends a=56, b=78, cin=0 with rsp_ready=1:
//      req_ready[0] in cycle 0; rsp_valid in cycle 3; sum=134, cout=0, id=0.
//   2. Req2 sends a=3794967295, b=500000000, cin=1:
//      sum=0, cout=1, id=2. Also a=32'hFFFFFFFF, b=0, cin=1 gives sum=0, cout=1.
//   3. All four requesters hold valid continuously:
//      grant order is 0,1,2,3,0,1. Results match each requester's operands and ids.
//      Issue spacing is exactly 4 cycles.
//   4. Hold rsp_ready=0 for 5 cycles during RESP (req1: 567+435+1):
//      rsp_sum=1003 stays stable. No req_ready is asserted while held.
//      ops_done increments once, only at the handshake.
//   5. Assert rst_n=0 in the middle of SETTLE:
//      rsp_valid never rises for that op; all outputs go to their reset values.
//      After reset, req0 is granted first even if last_grant was 0.
//   6. Use SETTLE_CYCLES=1 with 8624345+33356752+1:
//      rsp_valid in cycle 2, sum=41981098.
//      Random self-check: 10k ops against a+b+cin; ops_done equals the number of handshakes.

Source files
------------

// File: rtl/rp_adder_pkg.sv
// Shared width and controller state encoding for the shared ripple-carry adder block.
// Pure declarations; no logic, no latency, no flow control.
package rp_adder_pkg;

  localparam int ADD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rp_adder_32bit.sv
// Plain 32-bit ripple-carry adder; combinational, settles over a multicycle path.
// No flow control: outputs follow the inputs after the carry chain settles.
module rp_adder_32bit
  import rp_adder_pkg::*;
(
  input  logic [ADD_W-1:0] i_a,
  input  logic [ADD_W-1:0] i_b,
  input  logic             i_cin,
  output logic [ADD_W-1:0] o_sum,
  output logic             o_cout
);

  logic w_c;

  // Carry is a sequential variable so the chain is one explicit ripple, bit 0 upward.
  always_comb begin
    w_c   = i_cin;
    o_sum = '0;
    for (int i = 0; i < ADD_W; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester above i_last_grant, wrapping.
// Zero latency; grant is empty when no request is present.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_last_grant,
  output logic [NREQ-1:0] o_grant,
  output logic [ID_W-1:0] o_grant_idx
);

  logic            w_found;
  logic [ID_W-1:0] w_pos;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_pos       = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_pos = ID_W'((int'(i_last_grant) + off) % NREQ);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_grant_idx    = w_pos;
      end
    end
  end

endmodule

// File: rtl/rp_adder_share_ctrl.sv
// Round-robin sharing of one ripple adder; result valid SETTLE_CYCLES+1 cycles after accept.
// One op in flight: req_ready only in IDLE; the result is held until rsp_ready.
module rp_adder_share_ctrl
  import rp_adder_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADD_W-1:0]    req_a,
  input  logic [NREQ*ADD_W-1:0]    req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [ADD_W-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy,
  output logic [31:0]              ops_done
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NREQ - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [ID_W-1:0]  r_last_grant;
  logic [ADD_W-1:0] r_op_a;
  logic [ADD_W-1:0] r_op_b;
  logic             r_op_cin;
  logic [ID_W-1:0]  r_rsp_id;
  logic [ADD_W-1:0] r_rsp_sum;
  logic             r_rsp_cout;
  logic [31:0]      r_ops_done;

  logic [NREQ-1:0]  w_grant;
  logic [ID_W-1:0]  w_gidx;
  logic             w_issue;
  logic             w_capture;
  logic             w_hs;
  logic [ADD_W-1:0] w_sum;
  logic             w_cout;
  logic [ADD_W-1:0] w_a_arr [NREQ];
  logic [ADD_W-1:0] w_b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_a_arr[i] = req_a[ADD_W*i +: ADD_W];
    assign w_b_arr[i] = req_b[ADD_W*i +: ADD_W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_gidx)
  );

  // Adder inputs come only from the operand registers, so they are frozen for the whole multicycle window.
  rp_adder_32bit u_add (
    .i_a    (r_op_a),
    .i_b    (r_op_b),
    .i_cin  (r_op_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_grant) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_last_grant <= LAST_INIT;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_cin     <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_sum    <= '0;
      r_rsp_cout   <= 1'b0;
      r_ops_done   <= '0;
    end else begin
      if (w_issue) begin
        r_op_a       <= w_a_arr[w_gidx];
        r_op_b       <= w_b_arr[w_gidx];
        r_op_cin     <= req_cin[w_gidx];
        r_last_grant <= w_gidx;
        r_cnt        <= CNT_INIT;
      end else if (r_state == ST_SETTLE && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_rsp_sum  <= w_sum;
        r_rsp_cout <= w_cout;
        r_rsp_id   <= r_last_grant;
      end
      if (w_hs) begin
        r_ops_done <= r_ops_done + 32'd1;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign rsp_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_rp_adder_share_ctrl.sv
// Bench for rp_adder_share_ctrl: two instances (SETTLE_CYCLES 2 and 1) with
// per-instance scoreboards fed on request acceptance and drained on response handshake.
module tb_rp_adder_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req_valid [2];
  logic [3:0]  req_ready [2];
  logic [3:0]  req_cin   [2];
  logic [127:0] req_a    [2];
  logic [127:0] req_b    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_cout  [2];
  logic        busy      [2];
  logic [1:0]  rsp_id    [2];
  logic [31:0] rsp_sum   [2];
  logic [31:0] ops_done  [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt [2];
  int acc_cyc [2];
  logic [31:0] last_sum  [2];
  logic        last_cout [2];
  logic [1:0]  last_id   [2];
  int grant_log [$];
  int grant_cyc [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    localparam int S = (d == 0) ? 2 : 1;
    logic [34:0] sb [$];
    logic prev_v;

    rp_adder_share_ctrl #(
      .NREQ          (4),
      .SETTLE_CYCLES (S)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[d]),
      .req_ready (req_ready[d]),
      .req_a     (req_a[d]),
      .req_b     (req_b[d]),
      .req_cin   (req_cin[d]),
      .rsp_valid (rsp_valid[d]),
      .rsp_ready (rsp_ready[d]),
      .rsp_id    (rsp_id[d]),
      .rsp_sum   (rsp_sum[d]),
      .rsp_cout  (rsp_cout[d]),
      .busy      (busy[d]),
      .ops_done  (ops_done[d])
    );

    always @(negedge clk) begin
      int g;
      logic [31:0] ea, eb;
      logic        ec;
      logic [34:0] e;
      if (!rst_n) begin
        sb.delete();
        hs_cnt[d] = 0;
        prev_v    = 1'b0;
      end else begin
        chk($sformatf("d%0d_ready_onehot", d), 64'($onehot0(req_ready[d])), 64'd1);
        chk($sformatf("d%0d_ready_without_valid", d), 64'(req_ready[d] & ~req_valid[d]), 64'd0);
        if (|(req_valid[d] & req_ready[d])) begin
          g = 0;
          for (int i = 0; i < 4; i++) if (req_ready[d][i]) g = i;
          ea = req_a[d][32*g +: 32];
          eb = req_b[d][32*g +: 32];
          ec = req_cin[d][g];
          sb.push_back({2'(g), {1'b0, ea} + {1'b0, eb} + {32'd0, ec}});
          acc_cyc[d] = cyc;
          if (d == 0) begin
            grant_log.push_back(g);
            grant_cyc.push_back(cyc);
          end
        end
        if (rsp_valid[d] && !prev_v)
          chk($sformatf("d%0d_latency", d), 64'(cyc - acc_cyc[d]), 64'(S + 1));
        if (rsp_valid[d] && rsp_ready[d]) begin
          chk($sformatf("d%0d_rsp_expected", d), 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("d%0d_rsp_id", d), 64'(rsp_id[d]), 64'(e[34:33]));
            chk($sformatf("d%0d_rsp_sum", d), 64'(rsp_sum[d]), 64'(e[31:0]));
            chk($sformatf("d%0d_rsp_cout", d), 64'(rsp_cout[d]), 64'(e[32]));
          end
          last_sum[d]  = rsp_sum[d];
          last_cout[d] = rsp_cout[d];
          last_id[d]   = rsp_id[d];
          hs_cnt[d]++;
        end
        prev_v = rsp_valid[d];
      end
    end
  end

  task automatic set_req(input int d, input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
    req_a[d][32*i +: 32] = a;
    req_b[d][32*i +: 32] = b;
    req_cin[d][i]        = cin;
    req_valid[d][i]      = 1'b1;
  endtask

  task automatic await_accept(input int d, input int i, output int waited);
    waited = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (req_ready[d][i]) begin
        waited = n;
        break;
      end
    end
    chk($sformatf("d%0d_accept_in_time_req%0d", d, i), 64'(waited >= 0), 64'd1);
    @(posedge clk);
    #1;
    req_valid[d][i] = 1'b0;
  endtask

  task automatic issue(input int d, input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, output int waited);
    set_req(d, i, a, b, cin);
    await_accept(d, i, waited);
  endtask

  task automatic wait_hs(input int d, input int target);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(posedge clk);
      if (hs_cnt[d] >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("d%0d_hs_in_time", d), 64'(ok), 64'd1);
    #1;
  endtask

  task automatic chk_reset(input int d);
    chk($sformatf("d%0d_rst_req_ready", d), 64'(req_ready[d]), 64'd0);
    chk($sformatf("d%0d_rst_rsp_valid", d), 64'(rsp_valid[d]), 64'd0);
    chk($sformatf("d%0d_rst_rsp_id", d), 64'(rsp_id[d]), 64'd0);
    chk($sformatf("d%0d_rst_rsp_sum", d), 64'(rsp_sum[d]), 64'd0);
    chk($sformatf("d%0d_rst_rsp_cout", d), 64'(rsp_cout[d]), 64'd0);
    chk($sformatf("d%0d_rst_busy", d), 64'(busy[d]), 64'd0);
    chk($sformatf("d%0d_rst_ops_done", d), 64'(ops_done[d]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    int hs0;
    logic seen;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      req_cin[d]   = '0;
      req_a[d]     = '0;
      req_b[d]     = '0;
      rsp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: basic add, ready in the first cycle, result 3 cycles later
    issue(0, 0, 32'd56, 32'd78, 1'b0, w);
    chk("t1_ready_cycle0", 64'(w), 64'd0);
    wait_hs(0, 1);
    chk("t1_sum", 64'(last_sum[0]), 64'd134);
    chk("t1_cout", 64'(last_cout[0]), 64'd0);
    chk("t1_id", 64'(last_id[0]), 64'd0);

    // 2: wrap to zero with carry out
    issue(0, 2, 32'd3794967295, 32'd500000000, 1'b1, w);
    wait_hs(0, 2);
    chk("t2_sum", 64'(last_sum[0]), 64'd0);
    chk("t2_cout", 64'(last_cout[0]), 64'd1);
    chk("t2_id", 64'(last_id[0]), 64'd2);
    issue(0, 3, 32'hFFFF_FFFF, 32'd0, 1'b1, w);
    wait_hs(0, 3);
    chk("t2b_sum", 64'(last_sum[0]), 64'd0);
    chk("t2b_cout", 64'(last_cout[0]), 64'd1);
    chk("t2b_id", 64'(last_id[0]), 64'd3);

    // 3: all requesters valid, round-robin order and 4-cycle issue spacing
    base = grant_log.size();
    hs0  = hs_cnt[0];
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) set_req(0, i, 32'(1000 * (i + 1)), 32'(7 * i), i[0]);
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (grant_log.size() >= base + 6) break;
    end
    req_valid[0] = '0;
    chk("t3_grant_count", 64'(grant_log.size() - base), 64'd6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3_grant_order_%0d", k), 64'(grant_log[base + k]), 64'(k % 4));
    for (int k = 1; k < 6; k++)
      chk($sformatf("t3_spacing_%0d", k), 64'(grant_cyc[base + k] - grant_cyc[base + k - 1]), 64'd4);
    wait_hs(0, hs0 + 6);

    // 4: response backpressure holds the result and blocks new grants
    rsp_ready[0] = 1'b0;
    issue(0, 1, 32'd567, 32'd435, 1'b1, w);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t4_rsp_seen", 64'(seen), 64'd1);
    set_req(0, 0, 32'd2, 32'd3, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid", 64'(rsp_valid[0]), 64'd1);
      chk("t4_hold_sum", 64'(rsp_sum[0]), 64'd1003);
      chk("t4_hold_id", 64'(rsp_id[0]), 64'd1);
      chk("t4_hold_no_ready", 64'(req_ready[0]), 64'd0);
      chk("t4_hold_ops_done", 64'(ops_done[0]), 64'd9);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    await_accept(0, 0, w);
    chk("t4_grant_next_idle", 64'(w), 64'd1);
    chk("t4_ops_done_after", 64'(ops_done[0]), 64'd10);
    wait_hs(0, 11);
    chk("t4_req0_sum", 64'(last_sum[0]), 64'd5);

    // 5: reset during SETTLE discards the op and restores priority to requester 0
    issue(0, 0, 32'd10, 32'd20, 1'b0, w);
    chk("t5_busy_in_settle", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_no_rsp_after_reset", 64'(rsp_valid[0]), 64'd0);
    end
    @(posedge clk);
    #1;
    set_req(0, 0, 32'd5, 32'd6, 1'b0);
    set_req(0, 1, 32'd7, 32'd8, 1'b1);
    @(negedge clk);
    chk("t5_first_grant", 64'(req_ready[0]), 64'd1);
    @(posedge clk);
    #1;
    req_valid[0][0] = 1'b0;
    await_accept(0, 1, w);
    wait_hs(0, 2);
    chk("t5_ops_done", 64'(ops_done[0]), 64'd2);
    chk("t5_last_sum", 64'(last_sum[0]), 64'd16);

    // 6: SETTLE_CYCLES=1 instance, directed then random traffic
    issue(1, 0, 32'd8624345, 32'd33356752, 1'b1, w);
    wait_hs(1, 1);
    chk("t6_sum", 64'(last_sum[1]), 64'd41981098);
    chk("t6_cout", 64'(last_cout[1]), 64'd0);
    for (int k = 0; k < 10000; k++) begin
      issue(1, $urandom_range(0, 3), $urandom, $urandom, 1'($urandom_range(0, 1)), w);
      wait_hs(1, k + 2);
    end
    chk("t6_ops_done_vs_hs", 64'(ops_done[1]), 64'(hs_cnt[1]));
    chk("t6_ops_done_total", 64'(ops_done[1]), 64'd10001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
